// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_ctrl_pkg;

    // Controller state: normal flow or multiply occupying EX.
    typedef enum logic [0:0] {
        StRun = 1'b0,
        StMul = 1'b1
    } state_e;

    localparam int unsigned REG_ZERO        = 0;
    localparam int unsigned MUL_LAT_DEFAULT = 3;
    localparam int unsigned MUL_CNT_W       = 4;

    // Value loaded into the multiply down-counter on entry; entry and
    // release cycles are accounted for separately.
    function automatic logic [MUL_CNT_W-1:0] mul_cnt_init(input int unsigned lat);
        if (lat > 1) begin
            return MUL_CNT_W'(lat - 2);
        end
        return '0;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs from the pipeline stages and the stage-register controls
// returned to them. The pipeline side is the master, the controller the slave.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) ();
    logic                  enable;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_is_mul;
    logic                  mem_taken;

    logic                  pc_en;
    logic                  if_id_en;
    logic                  id_ex_en;
    logic                  ex_mem_en;
    logic                  mem_wb_en;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  ex_mem_flush;
    logic                  mul_busy;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_events;

    modport master (
        output enable, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_mem_read, ex_rd, ex_is_mul, mem_taken,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mul_busy,
               stall_cycles, flush_events
    );

    modport slave (
        input  enable, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_mem_read, ex_rd, ex_is_mul, mem_taken,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mul_busy,
               stall_cycles, flush_events
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the performance counters.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q, count_d;

    // Next value: step by one unless already at all-ones.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: load-use, multiply occupancy of EX and
// control-hazard flushes, with stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT    = MUL_LAT_DEFAULT,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input logic                   clk,
    input logic                   srst,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam bit                   MulStall   = (MUL_LAT > 1);
    localparam logic [MUL_CNT_W-1:0] MulCntInit = mul_cnt_init(MUL_LAT);
    localparam logic [REG_ADDR_W-1:0] RegZero   = REG_ADDR_W'(REG_ZERO);

    state_e               state_q, state_d;
    logic [MUL_CNT_W-1:0] mul_cnt_q, mul_cnt_d;

    logic load_use;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush;
    logic stall_inc, flush_inc;

    // Load-use: EX load writes a register the ID instruction reads; x0 never matches.
    always_comb begin
        load_use = hz.ex_mem_read && (hz.ex_rd != RegZero) &&
                   ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                    (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));
    end

    // Next-state and stage controls; everything idles when enable is low.
    always_comb begin
        state_d      = state_q;
        mul_cnt_d    = mul_cnt_q;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        if (hz.enable) begin
            if (hz.mem_taken) begin
                // Redirect wins over any stall detected in the same cycle.
                {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                {if_id_flush, id_ex_flush, ex_mem_flush}          = 3'b111;
                flush_inc = 1'b1;
                state_d   = StRun;
            end else begin
                unique case (state_q)
                    StRun: begin
                        if (hz.ex_is_mul && MulStall) begin
                            // Hold the multiply in EX, drain a bubble into MEM.
                            {ex_mem_en, mem_wb_en} = 2'b11;
                            ex_mem_flush = 1'b1;
                            mul_cnt_d    = MulCntInit;
                            state_d      = StMul;
                            stall_inc    = 1'b1;
                        end else if (load_use) begin
                            // Hold IF/ID, let the load advance, bubble into EX.
                            {id_ex_en, ex_mem_en, mem_wb_en} = 3'b111;
                            id_ex_flush = 1'b1;
                            stall_inc   = 1'b1;
                        end else begin
                            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                        end
                    end
                    StMul: begin
                        if (mul_cnt_q != '0) begin
                            {ex_mem_en, mem_wb_en} = 2'b11;
                            ex_mem_flush = 1'b1;
                            mul_cnt_d    = mul_cnt_q - MUL_CNT_W'(1);
                            stall_inc    = 1'b1;
                        end else begin
                            // Release: the multiply leaves EX; ex_is_mul refers to it.
                            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                            state_d = StRun;
                        end
                    end
                    default: begin
                        state_d = StRun;
                    end
                endcase
            end
        end
    end

    // State and multiply down-counter registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q   <= StRun;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .srst  (srst),
        .inc   (stall_inc),
        .count (hz.stall_cycles)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .srst  (srst),
        .inc   (flush_inc),
        .count (hz.flush_events)
    );

    assign hz.pc_en        = pc_en;
    assign hz.if_id_en     = if_id_en;
    assign hz.id_ex_en     = id_ex_en;
    assign hz.ex_mem_en    = ex_mem_en;
    assign hz.mem_wb_en    = mem_wb_en;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.ex_mem_flush = ex_mem_flush;
    assign hz.mul_busy     = (state_q == StMul);
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table plus reset-abort and
// saturation sequences, checked through an expected-result queue.
module tb_pipeline_hazard_ctrl;
    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned RAW     = 5;
    localparam int unsigned CW      = 4;

    typedef struct {
        logic           srst;
        logic           en;
        logic           mr;
        logic [RAW-1:0] rd;
        logic           ur1;
        logic [RAW-1:0] rs1;
        logic           ur2;
        logic [RAW-1:0] rs2;
        logic           mul;
        logic           taken;
        logic [4:0]     x_en;   // {pc, if_id, id_ex, ex_mem, mem_wb}
        logic [2:0]     x_fl;   // {if_id, id_ex, ex_mem}
        logic           x_busy;
        int             x_st;
        int             x_fe;
    } vec_t;

    logic clk;
    logic srst;
    int   n_pass;
    int   n_total;
    int   step_no;
    vec_t tbl[$];
    vec_t sb[$];

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(RAW), .CNT_W(CW)) hz_if ();

    pipeline_hazard_ctrl #(
        .MUL_LAT    (MUL_LAT),
        .REG_ADDR_W (RAW),
        .CNT_W      (CW)
    ) dut (
        .clk  (clk),
        .srst (srst),
        .hz   (hz_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input logic en, input logic mr,
                                input int rd, input logic ur1, input int rs1,
                                input logic ur2, input int rs2, input logic mul,
                                input logic taken, input logic [4:0] x_en,
                                input logic [2:0] x_fl, input logic x_busy,
                                input int x_st, input int x_fe);
        vec_t v;
        v.srst = s; v.en = en; v.mr = mr; v.rd = RAW'(rd);
        v.ur1 = ur1; v.rs1 = RAW'(rs1); v.ur2 = ur2; v.rs2 = RAW'(rs2);
        v.mul = mul; v.taken = taken;
        v.x_en = x_en; v.x_fl = x_fl; v.x_busy = x_busy; v.x_st = x_st; v.x_fe = x_fe;
        return v;
    endfunction

    // Shorthands: idle, load-use on rs2==5, multiply, frozen/released pattern.
    function automatic vec_t idle(input logic busy, input int st, input int fe);
        return mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 3'b000, busy, st, fe);
    endfunction

    function automatic vec_t lu(input int st, input int fe);
        return mk(0, 1, 1, 5, 0, 0, 1, 5, 0, 0, 5'b00111, 3'b010, 0, st, fe);
    endfunction

    function automatic vec_t mul_frz(input logic busy, input int st, input int fe);
        return mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00011, 3'b001, busy, st, fe);
    endfunction

    function automatic vec_t mul_rel(input int st, input int fe);
        return mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 5'b11111, 3'b000, 1, st, fe);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) begin
            n_pass++;
        end else begin
            $display("FAIL step %0d %s: got 0x%0h, expected 0x%0h", step_no, name, act, req);
        end
    endtask

    // Drive one vector, queue its expectation, compare on the falling edge.
    task automatic step(input vec_t v);
        vec_t e;
        srst                 = v.srst;
        hz_if.enable         = v.en;
        hz_if.ex_mem_read    = v.mr;
        hz_if.ex_rd          = v.rd;
        hz_if.id_uses_rs1    = v.ur1;
        hz_if.id_rs1         = v.rs1;
        hz_if.id_uses_rs2    = v.ur2;
        hz_if.id_rs2         = v.rs2;
        hz_if.ex_is_mul      = v.mul;
        hz_if.mem_taken      = v.taken;
        sb.push_back(v);
        @(negedge clk);
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL step %0d scoreboard: got empty queue, expected an entry", step_no);
        end else begin
            e = sb.pop_front();
            chk("en", int'({hz_if.pc_en, hz_if.if_id_en, hz_if.id_ex_en,
                            hz_if.ex_mem_en, hz_if.mem_wb_en}), int'(e.x_en));
            chk("flush", int'({hz_if.if_id_flush, hz_if.id_ex_flush,
                               hz_if.ex_mem_flush}), int'(e.x_fl));
            chk("mul_busy", int'(hz_if.mul_busy), int'(e.x_busy));
            chk("stall_cycles", int'(hz_if.stall_cycles), e.x_st);
            chk("flush_events", int'(hz_if.flush_events), e.x_fe);
        end
        step_no++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        step_no = 0;

        // Reset/idle, load-use variants, multiply, flush priority, pause, back-to-back.
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 0, 0, 0));
        tbl.push_back(idle(0, 0, 0));
        tbl.push_back(lu(0, 0));
        tbl.push_back(idle(0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 5'b11111, 3'b000, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 7, 0, 7, 0, 0, 0, 0, 5'b11111, 3'b000, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 7, 1, 7, 0, 0, 0, 0, 5'b00111, 3'b010, 0, 1, 0));
        tbl.push_back(idle(0, 2, 0));
        tbl.push_back(mul_frz(0, 2, 0));
        tbl.push_back(mul_frz(1, 3, 0));
        tbl.push_back(mul_rel(4, 0));
        tbl.push_back(idle(0, 4, 0));
        tbl.push_back(mk(0, 1, 1, 5, 0, 0, 1, 5, 1, 1, 5'b11111, 3'b111, 0, 4, 0));
        tbl.push_back(idle(0, 4, 1));
        tbl.push_back(mul_frz(0, 4, 1));
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 3'b000, 1, 5, 1));
        end
        tbl.push_back(mul_frz(1, 5, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 1, 6, 1));
        tbl.push_back(idle(0, 6, 1));
        tbl.push_back(mul_frz(0, 6, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 5'b11111, 3'b111, 1, 7, 1));
        tbl.push_back(idle(0, 7, 2));
        tbl.push_back(mk(0, 0, 1, 5, 0, 0, 1, 5, 0, 0, 5'b00000, 3'b000, 0, 7, 2));
        tbl.push_back(idle(0, 7, 2));
        tbl.push_back(mul_frz(0, 7, 2));
        tbl.push_back(mul_frz(1, 8, 2));
        tbl.push_back(mul_rel(9, 2));
        tbl.push_back(mul_frz(0, 9, 2));
        tbl.push_back(mul_frz(1, 10, 2));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 1, 11, 2));
        tbl.push_back(idle(0, 11, 2));

        srst = 1'b1;
        hz_if.enable = 1'b1;
        hz_if.ex_mem_read = 1'b0; hz_if.ex_rd = '0;
        hz_if.id_uses_rs1 = 1'b0; hz_if.id_rs1 = '0;
        hz_if.id_uses_rs2 = 1'b0; hz_if.id_rs2 = '0;
        hz_if.ex_is_mul = 1'b0; hz_if.mem_taken = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // Reset while in MUL (enable low) aborts to RUN and clears counters.
        step(mul_frz(0, 11, 2));
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 3'b000, 1, 12, 2));
        step(idle(0, 0, 0));

        // Twenty back-to-back load-use stalls saturate the 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            step(lu((i > 15) ? 15 : i, 0));
        end
        step(idle(0, 15, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish within bound");
        $fatal(1, "bench timed out");
    end
endmodule
